// File: rtl/periph_acc_router.sv
// Routes one cluster peripheral slave port to NB_HWPE HWPE config ports by address index, with
// a single registered outstanding response. Optional macro PERIPH_ACC_ROUTER_TIMEOUT_EN.
module periph_acc_router #(
   parameter int unsigned            NB_HWPE        = 2,
   parameter int unsigned            ADDR_WIDTH     = 32,
   parameter int unsigned            DATA_WIDTH     = 32,
   parameter int unsigned            ID_WIDTH       = 5,
   parameter int unsigned            IDX_LSB        = 10,
   parameter logic [DATA_WIDTH-1:0]  ERR_DATA       = DATA_WIDTH'(32'hBADACCE5),
   parameter int unsigned            TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          test_mode,
   input  logic                          speriph_req_i,
   input  logic [ADDR_WIDTH-1:0]         speriph_add_i,
   input  logic                          speriph_wen_i,
   input  logic [DATA_WIDTH-1:0]         speriph_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]       speriph_be_i,
   input  logic [ID_WIDTH-1:0]           speriph_id_i,
   output logic                          speriph_gnt_o,
   output logic                          speriph_r_valid_o,
   output logic [DATA_WIDTH-1:0]         speriph_r_rdata_o,
   output logic                          speriph_r_opc_o,
   output logic [ID_WIDTH-1:0]           speriph_r_id_o,
   output logic [NB_HWPE-1:0]            hwpe_req_o,
   output logic [ADDR_WIDTH-1:0]         hwpe_add_o,
   output logic                          hwpe_wen_o,
   output logic [DATA_WIDTH-1:0]         hwpe_wdata_o,
   output logic [DATA_WIDTH/8-1:0]       hwpe_be_o,
   output logic [ID_WIDTH-1:0]           hwpe_id_o,
   input  logic [NB_HWPE-1:0]            hwpe_gnt_i,
   input  logic [NB_HWPE-1:0]            hwpe_r_valid_i,
   input  logic [NB_HWPE*DATA_WIDTH-1:0] hwpe_r_rdata_i,
   input  logic [NB_HWPE-1:0]            hwpe_r_opc_i
);

   localparam int unsigned IdxW = (NB_HWPE > 1) ? $clog2(NB_HWPE) : 1;

   typedef enum logic {StIdle, StWait} state_e;

   state_e                state_q, state_d;
   logic [IdxW-1:0]       idx;
   logic                  mapped;
   logic [IdxW-1:0]       sel_q, sel_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic                  err_q, err_d;
   logic                  r_valid_q, r_valid_d;
   logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
   logic                  r_opc_q, r_opc_d;
   logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
   logic                  sel_valid, sel_opc;
   logic [DATA_WIDTH-1:0] sel_rdata;
   logic                  accept, resp_fire, timeout;
   logic                  unused_test_mode;

   assign unused_test_mode = test_mode;

   assign idx    = speriph_add_i[IDX_LSB +: IdxW];
   assign mapped = (32'(idx) < NB_HWPE);

   assign hwpe_add_o   = speriph_add_i;
   assign hwpe_wen_o   = speriph_wen_i;
   assign hwpe_wdata_o = speriph_wdata_i;
   assign hwpe_be_o    = speriph_be_i;
   assign hwpe_id_o    = speriph_id_i;

   // Response mux for the latched channel; an unmapped sel_q matches nothing.
   always_comb begin
      sel_valid = 1'b0;
      sel_opc   = 1'b0;
      sel_rdata = '0;
      for (int unsigned k = 0; k < NB_HWPE; k++) begin
         if (sel_q == IdxW'(k)) begin
            sel_valid = hwpe_r_valid_i[k];
            sel_opc   = hwpe_r_opc_i[k];
            sel_rdata = hwpe_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef PERIPH_ACC_ROUTER_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Fires in the WAIT cycle where the counter would step onto TIMEOUT_CYCLES.
   assign timeout = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign cnt_d   = (state_q == StWait) ? cnt_q + 1'b1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   assign accept    = (state_q == StIdle) && speriph_req_i && speriph_gnt_o;
   assign resp_fire = (state_q == StWait) && (err_q || sel_valid || timeout);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         sel_q     <= '0;
         id_q      <= '0;
         err_q     <= 1'b0;
         r_valid_q <= 1'b0;
         r_rdata_q <= '0;
         r_opc_q   <= 1'b0;
         r_id_q    <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         id_q      <= id_d;
         err_q     <= err_d;
         r_valid_q <= r_valid_d;
         r_rdata_q <= r_rdata_d;
         r_opc_q   <= r_opc_d;
         r_id_q    <= r_id_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      id_d      = id_q;
      err_d     = err_q;
      r_valid_d = 1'b0;
      r_rdata_d = r_rdata_q;
      r_opc_d   = r_opc_q;
      r_id_d    = r_id_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StWait;
               sel_d   = idx;
               id_d    = speriph_id_i;
               err_d   = !mapped;
            end
         end
         StWait: begin
            if (resp_fire) begin
               state_d   = StIdle;
               r_valid_d = 1'b1;
               r_id_d    = id_q;
               if (err_q || !sel_valid) begin
                  r_rdata_d = ERR_DATA;
                  r_opc_d   = 1'b1;
               end else begin
                  r_rdata_d = sel_rdata;
                  r_opc_d   = sel_opc;
               end
            end
         end
      endcase
   end

   always_comb begin
      hwpe_req_o    = '0;
      speriph_gnt_o = 1'b0;
      if (state_q == StIdle) begin
         if (mapped) begin
            for (int unsigned k = 0; k < NB_HWPE; k++) begin
               if (idx == IdxW'(k)) begin
                  hwpe_req_o[k] = speriph_req_i;
                  speriph_gnt_o = speriph_req_i && hwpe_gnt_i[k];
               end
            end
         end else begin
            speriph_gnt_o = speriph_req_i;
         end
      end
   end

   assign speriph_r_valid_o = r_valid_q;
   assign speriph_r_rdata_o = r_rdata_q;
   assign speriph_r_opc_o   = r_opc_q;
   assign speriph_r_id_o    = r_id_q;

endmodule

// File: tb/tb_periph_acc_router.sv
// Self-checking bench for periph_acc_router with three channels so index 3 is unmapped.
module tb_periph_acc_router;

   localparam int NB = 3;
   localparam int DW = 32;
   localparam logic [31:0] ERR = 32'hBADACCE5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            test_mode;
   logic            speriph_req_i;
   logic [31:0]     speriph_add_i;
   logic            speriph_wen_i;
   logic [31:0]     speriph_wdata_i;
   logic [3:0]      speriph_be_i;
   logic [4:0]      speriph_id_i;
   logic            speriph_gnt_o;
   logic            speriph_r_valid_o;
   logic [31:0]     speriph_r_rdata_o;
   logic            speriph_r_opc_o;
   logic [4:0]      speriph_r_id_o;
   logic [NB-1:0]   hwpe_req_o;
   logic [31:0]     hwpe_add_o;
   logic            hwpe_wen_o;
   logic [31:0]     hwpe_wdata_o;
   logic [3:0]      hwpe_be_o;
   logic [4:0]      hwpe_id_o;
   logic [NB-1:0]   hwpe_gnt_i;
   logic [NB-1:0]   hwpe_r_valid_i;
   logic [NB*DW-1:0] hwpe_r_rdata_i;
   logic [NB-1:0]   hwpe_r_opc_i;

   int n_tests = 0;
   int n_fail  = 0;

   periph_acc_router #(
      .NB_HWPE(NB), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(5), .IDX_LSB(10),
      .ERR_DATA(32'hBADACCE5), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .test_mode(test_mode),
      .speriph_req_i(speriph_req_i), .speriph_add_i(speriph_add_i),
      .speriph_wen_i(speriph_wen_i), .speriph_wdata_i(speriph_wdata_i),
      .speriph_be_i(speriph_be_i), .speriph_id_i(speriph_id_i),
      .speriph_gnt_o(speriph_gnt_o), .speriph_r_valid_o(speriph_r_valid_o),
      .speriph_r_rdata_o(speriph_r_rdata_o), .speriph_r_opc_o(speriph_r_opc_o),
      .speriph_r_id_o(speriph_r_id_o), .hwpe_req_o(hwpe_req_o), .hwpe_add_o(hwpe_add_o),
      .hwpe_wen_o(hwpe_wen_o), .hwpe_wdata_o(hwpe_wdata_o), .hwpe_be_o(hwpe_be_o),
      .hwpe_id_o(hwpe_id_o), .hwpe_gnt_i(hwpe_gnt_i), .hwpe_r_valid_i(hwpe_r_valid_i),
      .hwpe_r_rdata_i(hwpe_r_rdata_i), .hwpe_r_opc_i(hwpe_r_opc_i)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One transaction: idx picks the channel (3 = unmapped); noise 0 none, 1 all other channels
   // fire stray grants/valids, 2 random strays. Expected response follows from the routing rule.
   task automatic run_txn(input int idx, input logic [4:0] id, input int gnt_dly,
                          input int rsp_dly, input logic [31:0] data, input logic opc,
                          input int noise);
      logic        mapped;
      logic [2:0]  one, exp_req, g, v;
      logic [31:0] addr, exp_rdata, wd;
      logic        exp_opc;
      int          gd, nw;
      mapped    = (idx < NB);
      one       = 3'b001;
      exp_req   = mapped ? (one << idx) : 3'b000;
      exp_rdata = mapped ? data : ERR;
      exp_opc   = mapped ? opc : 1'b1;
      gd        = mapped ? gnt_dly : 0;
      nw        = mapped ? rsp_dly : 0;
      addr      = $urandom;
      addr[11:10] = idx[1:0];
      wd        = $urandom;
      speriph_add_i   = addr;
      speriph_wen_i   = 1'($urandom);
      speriph_wdata_i = wd;
      speriph_be_i    = 4'($urandom);
      speriph_id_i    = id;
      speriph_req_i   = 1'b1;
      for (int c = 0; c <= gd; c++) begin
         g = (noise == 1) ? ~exp_req : (noise == 2) ? 3'($urandom) : 3'b000;
         if (mapped) g[idx] = (c == gd);
         hwpe_gnt_i     = g;
         hwpe_r_valid_i = (noise != 0) ? 3'($urandom) : 3'b000;
         @(negedge clk);
         n_tests++;
         if (hwpe_req_o !== exp_req) begin
            n_fail++;
            $display("FAIL hwpe_req idx%0d: got %b exp %b", idx, hwpe_req_o, exp_req);
         end
         n_tests++;
         if (speriph_gnt_o !== (c == gd)) begin
            n_fail++;
            $display("FAIL gnt idx%0d cyc%0d: got %b exp %b", idx, c, speriph_gnt_o, c == gd);
         end
         if (c == 0) begin
            n_tests++;
            if (hwpe_add_o !== addr || hwpe_wdata_o !== wd || hwpe_id_o !== id) begin
               n_fail++;
               $display("FAIL broadcast: got %h/%h/%h exp %h/%h/%h", hwpe_add_o, hwpe_wdata_o,
                        hwpe_id_o, addr, wd, id);
            end
         end
         next_cycle();
      end
      speriph_req_i = 1'b0;
      hwpe_gnt_i    = (noise != 0) ? 3'($urandom) : 3'b000;
      for (int w = 0; w <= nw; w++) begin
         v = (noise == 1) ? ~exp_req : (noise == 2) ? 3'($urandom) : 3'b000;
         hwpe_r_opc_i   = 3'($urandom);
         hwpe_r_rdata_i = {$urandom, $urandom, $urandom};
         if (mapped) begin
            v[idx] = (w == nw);
            if (w == nw) begin
               hwpe_r_rdata_i[idx*DW +: DW] = data;
               hwpe_r_opc_i[idx] = opc;
            end
         end
         hwpe_r_valid_i = v;
         @(negedge clk);
         n_tests++;
         if (speriph_r_valid_o !== 1'b0 || hwpe_req_o !== 3'b000 || speriph_gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wait idx%0d w%0d: got rv=%b req=%b gnt=%b exp 0/000/0", idx, w,
                     speriph_r_valid_o, hwpe_req_o, speriph_gnt_o);
         end
         next_cycle();
      end
      hwpe_r_valid_i = (noise != 0) ? 3'($urandom) : 3'b000;
      hwpe_gnt_i     = 3'b000;
      @(negedge clk);
      n_tests++;
      if (speriph_r_valid_o !== 1'b1 || speriph_r_rdata_o !== exp_rdata ||
          speriph_r_opc_o !== exp_opc || speriph_r_id_o !== id) begin
         n_fail++;
         $display("FAIL resp idx%0d: got v=%b d=%h o=%b id=%0d exp 1 %h %b %0d", idx,
                  speriph_r_valid_o, speriph_r_rdata_o, speriph_r_opc_o, speriph_r_id_o,
                  exp_rdata, exp_opc, id);
      end
      next_cycle();
      hwpe_r_valid_i = 3'b000;
      @(negedge clk);
      n_tests++;
      if (speriph_r_valid_o !== 1'b0 || speriph_r_rdata_o !== exp_rdata) begin
         n_fail++;
         $display("FAIL resp_hold idx%0d: got v=%b d=%h exp 0 %h", idx, speriph_r_valid_o,
                  speriph_r_rdata_o, exp_rdata);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #7;
      n_tests++;
      if (speriph_r_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_rvalid: got %b exp 0", speriph_r_valid_o);
      end
      n_tests++;
      if (speriph_r_rdata_o !== 32'h0) begin
         n_fail++; $display("FAIL reset_rdata: got %h exp 0", speriph_r_rdata_o);
      end
      n_tests++;
      if (speriph_r_opc_o !== 1'b0 || speriph_r_id_o !== 5'd0) begin
         n_fail++; $display("FAIL reset_opc_id: got %b %0d exp 0 0", speriph_r_opc_o,
                            speriph_r_id_o);
      end
      n_tests++;
      if (speriph_gnt_o !== 1'b0 || hwpe_req_o !== 3'b000) begin
         n_fail++; $display("FAIL reset_gnt_req: got %b %b exp 0 000", speriph_gnt_o,
                            hwpe_req_o);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_read_ch1();
      run_txn(1, 5'd5, 0, 0, 32'h0000_1234, 1'b0, 0);
   endtask

   task automatic test_unmapped();
      run_txn(3, 5'd2, 0, 0, 32'h0, 1'b0, 0);
   endtask

   task automatic test_gnt_stall();
      run_txn(0, 5'd17, 3, 1, 32'hCAFE_0001, 1'b0, 0);
   endtask

   task automatic test_stray();
      run_txn(1, 5'd9, 0, 3, 32'h5555_AAAA, 1'b1, 1);
   endtask

   task automatic test_back_to_back();
      speriph_add_i = 32'h0000_0800;
      speriph_id_i  = 5'd7;
      speriph_req_i = 1'b1;
      hwpe_gnt_i    = 3'b100;
      next_cycle();
      speriph_req_i  = 1'b0;
      hwpe_gnt_i     = 3'b000;
      hwpe_r_valid_i = 3'b100;
      hwpe_r_opc_i   = 3'b000;
      hwpe_r_rdata_i[2*DW +: DW] = 32'hD00D_0002;
      next_cycle();
      hwpe_r_valid_i = 3'b000;
      speriph_add_i  = 32'h0000_0000;
      speriph_id_i   = 5'd9;
      speriph_req_i  = 1'b1;
      hwpe_gnt_i     = 3'b001;
      @(negedge clk);
      n_tests++;
      if (speriph_r_valid_o !== 1'b1 || speriph_r_rdata_o !== 32'hD00D_0002 ||
          speriph_r_id_o !== 5'd7) begin
         n_fail++; $display("FAIL b2b_first: got %b %h %0d exp 1 d00d0002 7",
                            speriph_r_valid_o, speriph_r_rdata_o, speriph_r_id_o);
      end
      n_tests++;
      if (speriph_gnt_o !== 1'b1 || hwpe_req_o !== 3'b001) begin
         n_fail++; $display("FAIL b2b_grant: got %b %b exp 1 001", speriph_gnt_o, hwpe_req_o);
      end
      next_cycle();
      speriph_req_i  = 1'b0;
      hwpe_gnt_i     = 3'b000;
      hwpe_r_valid_i = 3'b001;
      hwpe_r_opc_i   = 3'b001;
      hwpe_r_rdata_i[0 +: DW] = 32'hE000_000E;
      @(negedge clk);
      n_tests++;
      if (speriph_r_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL b2b_gap: got %b exp 0", speriph_r_valid_o);
      end
      next_cycle();
      hwpe_r_valid_i = 3'b000;
      @(negedge clk);
      n_tests++;
      if (speriph_r_valid_o !== 1'b1 || speriph_r_rdata_o !== 32'hE000_000E ||
          speriph_r_opc_o !== 1'b1 || speriph_r_id_o !== 5'd9) begin
         n_fail++; $display("FAIL b2b_second: got %b %h %b %0d exp 1 e000000e 1 9",
                            speriph_r_valid_o, speriph_r_rdata_o, speriph_r_opc_o,
                            speriph_r_id_o);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      speriph_add_i = 32'h0000_0400;
      speriph_id_i  = 5'd3;
      speriph_req_i = 1'b1;
      hwpe_gnt_i    = 3'b010;
      next_cycle();
      speriph_req_i = 1'b0;
      hwpe_gnt_i    = 3'b000;
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (speriph_r_valid_o !== 1'b0 || speriph_r_rdata_o !== 32'h0 ||
          speriph_r_opc_o !== 1'b0 || speriph_r_id_o !== 5'd0) begin
         n_fail++; $display("FAIL midreset_outputs: got %b %h %b %0d exp 0 0 0 0",
                            speriph_r_valid_o, speriph_r_rdata_o, speriph_r_opc_o,
                            speriph_r_id_o);
      end
      next_cycle();
      rst_n = 1'b1;
      hwpe_r_valid_i = 3'b010;
      hwpe_r_rdata_i[1*DW +: DW] = 32'h1111_2222;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_tests++;
         if (speriph_r_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_dropped c%0d: got %b exp 0", c,
                               speriph_r_valid_o);
         end
         next_cycle();
         hwpe_r_valid_i = 3'b000;
      end
      run_txn(1, 5'd21, 1, 0, 32'h0BAD_F00D, 1'b0, 0);
   endtask

   task automatic test_wait_long();
      int found;
      found = -1;
      speriph_add_i = 32'h0000_0000;
      speriph_id_i  = 5'd11;
      speriph_req_i = 1'b1;
      hwpe_gnt_i    = 3'b001;
      next_cycle();
      speriph_req_i = 1'b0;
      hwpe_gnt_i    = 3'b000;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (speriph_r_valid_o === 1'b1) begin
            found = c;
            break;
         end
         next_cycle();
      end
`ifdef PERIPH_ACC_ROUTER_TIMEOUT_EN
      n_tests++;
      if (found !== 9) begin
         n_fail++; $display("FAIL timeout_latency: got %0d exp 9", found);
      end
      n_tests++;
      if (speriph_r_opc_o !== 1'b1 || speriph_r_rdata_o !== ERR || speriph_r_id_o !== 5'd11) begin
         n_fail++; $display("FAIL timeout_resp: got %b %h %0d exp 1 %h 11", speriph_r_opc_o,
                            speriph_r_rdata_o, speriph_r_id_o, ERR);
      end
      next_cycle();
      hwpe_r_valid_i = 3'b001;
      @(negedge clk);
      n_tests++;
      if (speriph_r_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL timeout_stray: got %b exp 0", speriph_r_valid_o);
      end
      next_cycle();
      hwpe_r_valid_i = 3'b000;
`else
      n_tests++;
      if (found !== -1) begin
         n_fail++; $display("FAIL wait_persist: got response at %0d exp none", found);
      end
      hwpe_r_valid_i = 3'b001;
      hwpe_r_opc_i   = 3'b000;
      hwpe_r_rdata_i[0 +: DW] = 32'h7777_0000;
      next_cycle();
      hwpe_r_valid_i = 3'b000;
      @(negedge clk);
      n_tests++;
      if (speriph_r_valid_o !== 1'b1 || speriph_r_rdata_o !== 32'h7777_0000 ||
          speriph_r_id_o !== 5'd11) begin
         n_fail++; $display("FAIL wait_late_resp: got %b %h %0d exp 1 77770000 11",
                            speriph_r_valid_o, speriph_r_rdata_o, speriph_r_id_o);
      end
      next_cycle();
`endif
      run_txn(2, 5'd30, 0, 2, 32'hABCD_EF01, 1'b1, 0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         run_txn(int'($urandom_range(0, 3)), 5'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), $urandom, 1'($urandom),
                 ($urandom_range(0, 1) == 1) ? 2 : 0);
         repeat ($urandom_range(0, 2)) next_cycle();
      end
   endtask

   initial begin
      test_mode       = 1'b0;
      speriph_req_i   = 1'b0;
      speriph_add_i   = '0;
      speriph_wen_i   = 1'b1;
      speriph_wdata_i = '0;
      speriph_be_i    = '0;
      speriph_id_i    = '0;
      hwpe_gnt_i      = '0;
      hwpe_r_valid_i  = '0;
      hwpe_r_rdata_i  = '0;
      hwpe_r_opc_i    = '0;
      rst_n           = 1'b0;
      test_reset();
      test_read_ch1();
      test_unmapped();
      test_gnt_stall();
      test_stray();
      test_back_to_back();
      test_reset_mid();
      test_wait_long();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
